// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchronizer, start/data/parity/stop FSM,
// and a first-word-fall-through FIFO with registered head and sticky overflow.
module uart_rx_param #(
   parameter int unsigned CLK_DIV    = 106,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   input  logic                 rd_en,
   input  logic                 ovf_clr,
   output logic                 rd_valid,
   output logic [DATA_BITS-1:0] rd_data,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overflow,
   output logic                 busy
);

   localparam int unsigned CNT_W  = $clog2(CLK_DIV);
   localparam int unsigned BIT_W  = $clog2(DATA_BITS);
   localparam int unsigned AW     = $clog2(FIFO_DEPTH);
   localparam int unsigned PW     = AW + 1;
   localparam int unsigned WORD_W = DATA_BITS + 2;
   localparam int unsigned HALF   = CLK_DIV / 2 - 1;
   localparam int unsigned FULL   = CLK_DIV - 1;
   localparam bit          PAR_ODD = (PARITY == 2);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
   } state_t;

   state_t               state_q, state_d;
   logic                 rx_meta_q, rxs_q, rxs_prev_q;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [BIT_W-1:0]     bitn_q, bitn_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 perr_q, perr_d;
   logic                 ferr_q, ferr_d;
   logic                 tick_c, stop_fe_c, push_c;
   logic [WORD_W-1:0]    push_word_c;

   logic [WORD_W-1:0]    mem [FIFO_DEPTH];
   logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [WORD_W-1:0]    head_q, head_d;
   logic                 empty_c, full_c, pop_c, push_ok_c, drop_c;
   logic                 rd_valid_q, overflow_q, busy_q;

   // Synchronizer plus one extra stage for falling-edge detection; idle level is high
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta_q  <= 1'b1;
         rxs_q      <= 1'b1;
         rxs_prev_q <= 1'b1;
      end else begin
         rx_meta_q  <= rx;
         rxs_q      <= rx_meta_q;
         rxs_prev_q <= rxs_q;
      end
   end

   assign tick_c      = (cnt_q == '0);
   assign stop_fe_c   = ferr_q | ~rxs_q;
   assign push_word_c = {stop_fe_c, perr_q, shift_q};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bitn_q  <= '0;
         shift_q <= '0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bitn_q  <= bitn_d;
         shift_q <= shift_d;
         perr_q  <= perr_d;
         ferr_q  <= ferr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bitn_d  = bitn_q;
      shift_d = shift_q;
      perr_d  = perr_q;
      ferr_d  = ferr_q;
      push_c  = 1'b0;
      if (state_q != S_IDLE && state_q != S_WAIT_HIGH && !tick_c) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
      case (state_q)
         S_IDLE: begin
            if (rxs_prev_q && !rxs_q) begin
               cnt_d   = CNT_W'(HALF);
               bitn_d  = '0;
               perr_d  = 1'b0;
               ferr_d  = 1'b0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (tick_c) begin
               if (rxs_q) begin
                  state_d = S_IDLE;
               end else begin
                  cnt_d   = CNT_W'(FULL);
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (tick_c) begin
               shift_d = {rxs_q, shift_q[DATA_BITS-1:1]};
               cnt_d   = CNT_W'(FULL);
               if (bitn_q == BIT_W'(DATA_BITS - 1)) begin
                  bitn_d  = '0;
                  state_d = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bitn_d = bitn_q + BIT_W'(1);
               end
            end
         end
         S_PARITY: begin
            if (tick_c) begin
               perr_d  = (^shift_q) ^ rxs_q ^ PAR_ODD;
               cnt_d   = CNT_W'(FULL);
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (tick_c) begin
               ferr_d = stop_fe_c;
               cnt_d  = CNT_W'(FULL);
               if (bitn_q == BIT_W'(STOP_BITS - 1)) begin
                  // Errored words are still delivered; a low line must go high before re-arming
                  push_c  = 1'b1;
                  bitn_d  = '0;
                  cnt_d   = '0;
                  state_d = stop_fe_c ? S_WAIT_HIGH : S_IDLE;
               end else begin
                  bitn_d = bitn_q + BIT_W'(1);
               end
            end
         end
         S_WAIT_HIGH: begin
            if (rxs_q) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // FIFO: pop is evaluated before push, so a full FIFO accepts a word when popped the same cycle
   assign empty_c   = (wr_ptr_q == rd_ptr_q);
   assign full_c    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop_c     = rd_en && !empty_c;
   assign push_ok_c = push_c && (!full_c || pop_c);
   assign drop_c    = push_c && !push_ok_c;
   assign wr_ptr_d  = wr_ptr_q + PW'(push_ok_c);
   assign rd_ptr_d  = rd_ptr_q + PW'(pop_c);

   always_comb begin
      head_d = head_q;
      if (wr_ptr_d != rd_ptr_d) begin
         if (push_ok_c && (wr_ptr_q == rd_ptr_d)) begin
            head_d = push_word_c;
         end else begin
            head_d = mem[rd_ptr_d[AW-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok_c) begin
         mem[wr_ptr_q[AW-1:0]] <= push_word_c;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         head_q     <= '0;
         rd_valid_q <= 1'b0;
         overflow_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         head_q     <= head_d;
         rd_valid_q <= (wr_ptr_d != rd_ptr_d);
         busy_q     <= (state_d != S_IDLE);
         if (drop_c) begin
            overflow_q <= 1'b1;
         end else if (ovf_clr) begin
            overflow_q <= 1'b0;
         end
      end
   end

   assign rd_valid   = rd_valid_q;
   assign rd_data    = head_q[DATA_BITS-1:0];
   assign parity_err = head_q[DATA_BITS];
   assign frame_err  = head_q[DATA_BITS+1];
   assign overflow   = overflow_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: four receiver configurations, table-driven frames,
// and hand-written sequences for latency, glitch, break, FIFO overflow and reset.
module tb_uart_rx_param;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic       rx_r      [4];
   logic       rd_en_r   [4];
   logic       ovf_clr_r [4];
   logic       rv        [4];
   logic       fe        [4];
   logic       pe        [4];
   logic       ovf       [4];
   logic       bsy       [4];
   logic [8:0] rdd       [4];
   logic [7:0] d0, d1, d2;
   logic [6:0] d3;

   int checks = 0;
   int errors = 0;
   logic [10:0] sbq [$];

   typedef struct {
      int         inst;
      logic [8:0] data;
      logic       pbit;
      logic [1:0] stops;
      logic       fe;
      logic       pe;
   } vec_t;
   localparam int NV = 10;
   vec_t vecs [NV];

   uart_rx_param #(.CLK_DIV(106), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
      .clk(clk), .reset(reset), .rx(rx_r[0]), .rd_en(rd_en_r[0]), .ovf_clr(ovf_clr_r[0]),
      .rd_valid(rv[0]), .rd_data(d0), .frame_err(fe[0]), .parity_err(pe[0]),
      .overflow(ovf[0]), .busy(bsy[0]));
   uart_rx_param #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
      .clk(clk), .reset(reset), .rx(rx_r[1]), .rd_en(rd_en_r[1]), .ovf_clr(ovf_clr_r[1]),
      .rd_valid(rv[1]), .rd_data(d1), .frame_err(fe[1]), .parity_err(pe[1]),
      .overflow(ovf[1]), .busy(bsy[1]));
   uart_rx_param #(.CLK_DIV(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(2)) u2 (
      .clk(clk), .reset(reset), .rx(rx_r[2]), .rd_en(rd_en_r[2]), .ovf_clr(ovf_clr_r[2]),
      .rd_valid(rv[2]), .rd_data(d2), .frame_err(fe[2]), .parity_err(pe[2]),
      .overflow(ovf[2]), .busy(bsy[2]));
   uart_rx_param #(.CLK_DIV(15), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
      .clk(clk), .reset(reset), .rx(rx_r[3]), .rd_en(rd_en_r[3]), .ovf_clr(ovf_clr_r[3]),
      .rd_valid(rv[3]), .rd_data(d3), .frame_err(fe[3]), .parity_err(pe[3]),
      .overflow(ovf[3]), .busy(bsy[3]));

   always_comb begin
      rdd[0] = {1'b0, d0};
      rdd[1] = {1'b0, d1};
      rdd[2] = {1'b0, d2};
      rdd[3] = {2'b00, d3};
   end

   function automatic int div_of(input int i);
      case (i)
         0:       return 106;
         1, 2:    return 16;
         default: return 15;
      endcase
   endfunction
   function automatic int nb_of(input int i);   return (i == 3) ? 7 : 8; endfunction
   function automatic int par_of(input int i);  return (i == 1) ? 1 : ((i == 2) ? 2 : 0); endfunction
   function automatic int stop_of(input int i); return (i == 3) ? 2 : 1; endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic send_frame(input int inst, input logic [8:0] data, input logic pbit,
                             input logic [1:0] stops);
      int div;
      div = div_of(inst);
      rx_r[inst] = 1'b0;
      wait_cyc(div);
      for (int i = 0; i < nb_of(inst); i++) begin
         rx_r[inst] = data[i];
         wait_cyc(div);
      end
      if (par_of(inst) != 0) begin
         rx_r[inst] = pbit;
         wait_cyc(div);
      end
      for (int i = 0; i < stop_of(inst); i++) begin
         rx_r[inst] = stops[i];
         wait_cyc(div);
      end
      rx_r[inst] = 1'b1;
   endtask

   // Waits (bounded) for a word, compares it with the scoreboard head, then pops it
   task automatic expect_word(input int inst, input string name);
      int n;
      logic [10:0] exp_w;
      n = 0;
      while (!rv[inst] && n < 5000) begin
         wait_cyc(1);
         n++;
      end
      if (!rv[inst]) begin
         checks++;
         errors++;
         $display("FAIL %s: rd_valid timeout after %0d cycles", name, n);
         return;
      end
      if (sbq.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL %s: unexpected word %0h", name, {fe[inst], pe[inst], rdd[inst]});
      end else begin
         exp_w = sbq.pop_front();
         chk(name, 32'({fe[inst], pe[inst], rdd[inst]}), 32'(exp_w));
      end
      rd_en_r[inst] = 1'b1;
      wait_cyc(1);
      rd_en_r[inst] = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rx_r[i] = 1'b1; rd_en_r[i] = 1'b0; ovf_clr_r[i] = 1'b0;
      end
      vecs[0] = '{0, 9'h0A3, 1'b0, 2'b01, 1'b0, 1'b0};
      vecs[1] = '{1, 9'h003, 1'b1, 2'b01, 1'b0, 1'b1};
      vecs[2] = '{1, 9'h003, 1'b0, 2'b01, 1'b0, 1'b0};
      vecs[3] = '{1, 9'h081, 1'b0, 2'b00, 1'b1, 1'b0};
      vecs[4] = '{2, 9'h003, 1'b1, 2'b01, 1'b0, 1'b0};
      vecs[5] = '{2, 9'h0C4, 1'b1, 2'b01, 1'b0, 1'b1};
      vecs[6] = '{3, 9'h05A, 1'b0, 2'b11, 1'b0, 1'b0};
      vecs[7] = '{3, 9'h021, 1'b0, 2'b01, 1'b1, 1'b0};
      vecs[8] = '{3, 9'h07F, 1'b0, 2'b10, 1'b1, 1'b0};
      vecs[9] = '{3, 9'h000, 1'b0, 2'b11, 1'b0, 1'b0};
      wait_cyc(5);

      for (int i = 0; i < 4; i++) begin
         chk("reset_rd_valid", 32'(rv[i]), 0);
         chk("reset_rd_data", 32'(rdd[i]), 0);
         chk("reset_flags", 32'({fe[i], pe[i]}), 0);
         chk("reset_overflow", 32'(ovf[i]), 0);
         chk("reset_busy", 32'(bsy[i]), 0);
      end
      reset = 1'b0;
      wait_cyc(5);

      // 8N1 byte with rd_valid latency measured from the start edge
      begin
         int lat;
         bit seen;
         lat = 0;
         seen = 1'b0;
         sbq.push_back({2'b00, 9'h055});
         fork
            send_frame(0, 9'h055, 1'b0, 2'b01);
            for (int c = 1; c <= 1200 && !seen; c++) begin
               wait_cyc(1);
               if (rv[0]) begin
                  lat = c;
                  seen = 1'b1;
               end
            end
         join
         chk("rd_valid_latency", 32'(lat), 32'(2 + 1 + 53 + 9 * 106));
         expect_word(0, "byte_55");
      end

      for (int v = 0; v < NV; v++) begin
         sbq.push_back({vecs[v].fe, vecs[v].pe, vecs[v].data});
         send_frame(vecs[v].inst, vecs[v].data, vecs[v].pbit, vecs[v].stops);
         expect_word(vecs[v].inst, $sformatf("vec%0d", v));
         wait_cyc(div_of(vecs[v].inst));
         chk($sformatf("vec%0d_drained", v), 32'(rv[vecs[v].inst]), 0);
      end

      // Glitch: short low pulse must not produce a word
      rx_r[0] = 1'b0;
      wait_cyc(10);
      chk("glitch_busy_high", 32'(bsy[0]), 1);
      wait_cyc(10);
      rx_r[0] = 1'b1;
      wait_cyc(40);
      chk("glitch_busy_low", 32'(bsy[0]), 0);
      chk("glitch_no_word", 32'(rv[0]), 0);

      // Break: 3000 cycles low gives exactly one framing-error word
      sbq.push_back({2'b10, 9'h000});
      rx_r[0] = 1'b0;
      wait_cyc(2000);
      chk("break_busy", 32'(bsy[0]), 1);
      wait_cyc(1000);
      rx_r[0] = 1'b1;
      wait_cyc(10);
      expect_word(0, "break_word");
      wait_cyc(300);
      chk("break_single", 32'(rv[0]), 0);
      chk("break_idle", 32'(bsy[0]), 0);

      // FIFO overflow, ovf_clr, and pop coinciding with a push while full
      for (int v = 8'h10; v <= 8'h14; v++) begin
         if (v < 8'h14) sbq.push_back({2'b00, 9'(v)});
         send_frame(0, 9'(v), 1'b0, 2'b01);
      end
      chk("ovf_set", 32'(ovf[0]), 1);
      chk("fifo_full_valid", 32'(rv[0]), 1);
      chk("fifo_head", 32'(rdd[0]), 32'h10);
      ovf_clr_r[0] = 1'b1;
      wait_cyc(1);
      ovf_clr_r[0] = 1'b0;
      chk("ovf_clr", 32'(ovf[0]), 0);
      fork
         send_frame(0, 9'h015, 1'b0, 2'b01);
         begin
            logic [10:0] exp_w;
            wait_cyc(2 + 1 + 53 + 9 * 106 - 1);
            exp_w = sbq.pop_front();
            chk("pop_at_push_head", 32'({fe[0], pe[0], rdd[0]}), 32'(exp_w));
            rd_en_r[0] = 1'b1;
            wait_cyc(1);
            rd_en_r[0] = 1'b0;
         end
      join
      sbq.push_back({2'b00, 9'h015});
      chk("ovf_not_set_on_pop", 32'(ovf[0]), 0);
      for (int k = 0; k < 4; k++) expect_word(0, $sformatf("fifo_word%0d", k));
      wait_cyc(2);
      chk("fifo_empty", 32'(rv[0]), 0);

      // Reset in the 4th data bit discards the partial frame
      rx_r[0] = 1'b0;
      wait_cyc(470);
      chk("midframe_busy", 32'(bsy[0]), 1);
      reset = 1'b1;
      rx_r[0] = 1'b1;
      wait_cyc(3);
      chk("midreset_busy", 32'(bsy[0]), 0);
      chk("midreset_valid", 32'(rv[0]), 0);
      reset = 1'b0;
      wait_cyc(20);
      chk("postreset_busy", 32'(bsy[0]), 0);
      sbq.push_back({2'b00, 9'h07E});
      send_frame(0, 9'h07E, 1'b0, 2'b01);
      expect_word(0, "after_reset_7E");
      wait_cyc(200);
      chk("after_reset_single", 32'(rv[0]), 0);
      chk("scoreboard_empty", 32'(sbq.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised, synthesizable UART receiver for the SoC serial path. It replaces fixed-rate, 8N1-only serial sampling with a configurable receiver: divider, data width, parity and stop-bit count are parameters. Framing and parity errors are detected and reported. Received words are buffered in a small first-word-fall-through FIFO. It sits between the board RX pin and the SoC bus/console logic, and also serves as a synthesizable serial monitor in benches.

## Interface
Parameters:
- CLK_DIV, 106, clk cycles per bit; minimum 4.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits per frame; 1 or 2.
- FIFO_DEPTH, 4, number of FIFO entries; power of two, ≥2.

Ports (one clock `clk`; reset `reset` is asynchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  async active-high reset.
- rx  in  1  serial input; asynchronous; idle level is high.
- rd_en  in  1  pop the FIFO head; ignored when empty.
- ovf_clr  in  1  clears the sticky `overflow` flag.
- rd_valid  out  1  FIFO not empty.
- rd_data  out  DATA_BITS  data of the FIFO head, LSB-first as received.
- frame_err  out  1  frame error flag of the FIFO head.
- parity_err  out  1  parity error flag of the FIFO head; always 0 when PARITY=0.
- overflow  out  1  sticky flag: a word was dropped because the FIFO was full.
- busy  out  1  receiver FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer; the FSM uses only the synced value `rxs`.
- **IDLE**: on a falling edge of `rxs` (previous sample 1, current 0), load the bit counter with CLK_DIV/2 − 1 and go to START.
- **START**: when the counter reaches 0, sample `rxs`.
  - If 1: glitch. Return to IDLE; no word is produced.
  - If 0: reload the counter with CLK_DIV − 1 and go to DATA.
- **DATA**: sample at each counter expiry and shift in LSB first. After DATA_BITS samples, go to PARITY if PARITY≠0, else go to STOP.
- **PARITY**: sample one bit.
  - Even mode: `parity_err` = XOR of the data bits and the parity bit.
  - Odd mode: `parity_err` is the inverse of that XOR.
- **STOP**: sample STOP_BITS bits. `frame_err` is set if any stop sample is 0.
  - At the last stop sample, push {frame_err, parity_err, data} to the FIFO. The word is pushed even when it carries errors.
  - Without frame error: go to IDLE the same cycle.
  - With frame error: go to WAIT_HIGH.
- **WAIT_HIGH**: stay until `rxs` = 1, then go to IDLE. This prevents a break condition from producing repeated words.
- Counter width is $clog2(CLK_DIV). For odd CLK_DIV, the half-bit delay is floor(CLK_DIV/2).
- **FIFO**:
  - Pointers are one bit wider than log2(FIFO_DEPTH) for full/empty detection; they wrap modulo 2·FIFO_DEPTH.
  - Push when full: the new word is dropped, `overflow` is set, and FIFO contents are unchanged.
  - Push and pop in the same cycle while full: the pop happens first, the push succeeds, and `overflow` does not set.
  - Push and pop in the same cycle while empty: only the push takes effect.
- **overflow**: set by a dropped word and cleared by `ovf_clr`. If both occur in the same cycle, set wins.
- **Reset** (including mid-frame): FSM goes to IDLE, counters are 0, FIFO is empty, and the synchronizer loads 1s. A partial frame is discarded.

## Timing
- Reset values of outputs:
  - rd_valid = 0, rd_data = 0, frame_err = 0, parity_err = 0, overflow = 0, busy = 0.
- Latency from the `rx` pin falling edge to the start-bit sample is 2 + 1 + CLK_DIV/2 cycles: 2 cycles of synchronizer, 1 cycle of edge detect, then the half-bit delay.
- The last stop sample occurs (DATA_BITS + (PARITY≠0) + STOP_BITS) × CLK_DIV cycles after the start-bit sample.
- `rd_valid` rises on the cycle after the push.
- `busy` rises on the cycle after the edge is detected. It falls on the cycle after the transition to IDLE.
- `rd_data` and the flags are registered FIFO head outputs. They update on the cycle after a pop.

## Test plan
- **8N1 byte**: CLK_DIV=106, send 0x55 and then 0xA3 → two words, 0x55 then 0xA3, flags 0. `rd_valid` rises 2+1+53+9×106 cycles after the start edge.
- **Glitch**: `rx` low for 20 cycles, then high → no push; `busy` returns to 0 within 60 cycles.
- **Parity**: PARITY=1, send 0x03 with parity bit 1 → rd_data=0x03, parity_err=1. Send 0x03 with parity bit 0 → parity_err=0. PARITY=2 with parity bit 1 → parity_err=0.
- **Break and 2 stop bits**:
  - Hold `rx` low for 3000 cycles → exactly one word, 0x00, with frame_err=1.
  - With STOP_BITS=2, a second stop bit of 0 → frame_err=1.
- **FIFO**: FIFO_DEPTH=4, send 0x10..0x14 with no reads → `overflow`=1 and the FIFO holds 0x10..0x13. Pulse `rd_en` exactly at a push while full → no new overflow. `ovf_clr` clears the flag.
- **Reset mid-frame**: assert `reset` during the 4th data bit, release, then send 0x7E → only 0x7E is received, with no flags.
